lcd_fb_sched: RTL and testbench

- Triple-buffer scheduler for the 160x144x15 LCD frame store.
- Owns three bank roles: writer (W), reader (R) and spare (S).
- Generates write addresses from the PPU pixel stream and read addresses for the scan-out side.
- Hands completed frames to scan-out without tearing: a complete frame is never partially overwritten while being read, and incomplete frames are never shown.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_fb_sched_if.sv | 37 +++
 rtl/lcd_fb_bank_roles.sv | 67 ++++++
 rtl/lcd_fb_sched.sv | 100 ++++++++++
 tb/tb_lcd_fb_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// Shared LCD frame-store geometry, bank index type and bank base address lookup.
package lcd_pkg;

  localparam int LCD_W      = 160;
  localparam int LCD_H      = 144;
  localparam int LCD_PIXELS = LCD_W * LCD_H;
  localparam int LCD_AW     = 17;

  typedef logic [1:0] bank_t;

  localparam bank_t BANK0 = 2'd0;
  localparam bank_t BANK1 = 2'd1;
  localparam bank_t BANK2 = 2'd2;

  // Constant mux instead of idx*PIXELS; index 3 never occurs.
  function automatic logic [LCD_AW-1:0] bank_base(input bank_t idx);
    case (idx)
      BANK1:   bank_base = LCD_AW'(LCD_PIXELS);
      BANK2:   bank_base = LCD_AW'(2 * LCD_PIXELS);
      default: bank_base = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_fb_sched_if.sv
`default_nettype none
// PPU pixel stream, scan-out control and frame-store/status signals of the scheduler.
interface lcd_fb_sched_if #(
  parameter int AW = 17,
  parameter int CW = 8
);
  logic          ce_cpu;
  logic          clkena;
  logic [14:0]   data;
  logic          lcd_off;
  logic          rd_frame_start;
  logic          rd_step;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [14:0]   wr_data;
  logic [AW-1:0] rd_addr;
  logic [1:0]    wr_bank;
  logic [1:0]    rd_bank;
  logic          spare_valid;
  logic          frame_done;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] repeat_cnt;
  logic [CW-1:0] partial_cnt;

  modport master (
    output ce_cpu, clkena, data, lcd_off, rd_frame_start, rd_step,
    input  wr_en, wr_addr, wr_data, rd_addr, wr_bank, rd_bank,
    input  spare_valid, frame_done, drop_cnt, repeat_cnt, partial_cnt
  );

  modport slave (
    input  ce_cpu, clkena, data, lcd_off, rd_frame_start, rd_step,
    output wr_en, wr_addr, wr_data, rd_addr, wr_bank, rd_bank,
    output spare_valid, frame_done, drop_cnt, repeat_cnt, partial_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lcd_fb_bank_roles.sv
`default_nettype none
// Writer/reader/spare bank role tracking; a commit resolves before a same-cycle reader swap.
module lcd_fb_bank_roles
  import lcd_pkg::*;
(
  input  wire logic  clk_sys,
  input  wire logic  reset_n,
  input  wire logic  commit,
  input  wire logic  rd_start,
  output bank_t      w_bank,
  output bank_t      r_bank,
  output bank_t      r_bank_next,
  output logic       spare_valid,
  output logic       drop,
  output logic       rep
);

  bank_t w_q, r_q, s_q;
  bank_t w_n, r_n, s_n;
  logic  sv_q, sv_n;

  always_comb begin
    w_n  = w_q;
    r_n  = r_q;
    s_n  = s_q;
    sv_n = sv_q;
    drop = 1'b0;
    rep  = 1'b0;
    if (commit) begin
      w_n  = s_q;
      s_n  = w_q;
      sv_n = 1'b1;
      drop = sv_q;
    end
    // The reader sees the spare as updated by a same-cycle commit.
    if (rd_start) begin
      if (sv_n) begin
        r_n  = s_n;
        s_n  = r_q;
        sv_n = 1'b0;
      end else begin
        rep = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      w_q  <= BANK0;
      r_q  <= BANK1;
      s_q  <= BANK2;
      sv_q <= 1'b0;
    end else begin
      w_q  <= w_n;
      r_q  <= r_n;
      s_q  <= s_n;
      sv_q <= sv_n;
    end
  end

  assign w_bank      = w_q;
  assign r_bank      = r_q;
  assign r_bank_next = r_n;
  assign spare_valid = sv_q;

endmodule
`default_nettype wire

// File: rtl/lcd_fb_sched.sv
`default_nettype none
// Triple-buffer frame-store scheduler: write/read address generation and tear-free frame hand-off.
module lcd_fb_sched
  import lcd_pkg::*;
#(
  parameter int PIXELS = LCD_PIXELS,
  parameter int AW     = LCD_AW,
  parameter int CW     = 8
) (
  input  wire logic     clk_sys,
  input  wire logic     reset_n,
  lcd_fb_sched_if.slave bus
);

  localparam int          PW       = $clog2(PIXELS + 1);
  localparam logic [PW-1:0] PTR_FULL = PW'(PIXELS);
  localparam logic [PW-1:0] PTR_LAST = PW'(PIXELS - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic          lcd_off_q;
  logic          frame_end, accept, commit, discard;
  bank_t         w_bank, r_bank, r_bank_next;
  logic          spare_valid, drop, rep;

  assign frame_end = bus.lcd_off & ~lcd_off_q;
  assign accept    = bus.ce_cpu & bus.clkena & ~bus.lcd_off & (wr_ptr < PTR_FULL);
  assign commit    = frame_end & (wr_ptr == PTR_FULL);
  assign discard   = frame_end & (wr_ptr != '0) & (wr_ptr < PTR_FULL);

  lcd_fb_bank_roles u_roles (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .commit      (commit),
    .rd_start    (bus.rd_frame_start),
    .w_bank      (w_bank),
    .r_bank      (r_bank),
    .r_bank_next (r_bank_next),
    .spare_valid (spare_valid),
    .drop        (drop),
    .rep         (rep)
  );

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic en);
    sat_inc = (en && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
  endfunction

  always_comb begin
    rd_ptr_next = rd_ptr;
    if (bus.rd_frame_start)
      rd_ptr_next = '0;
    else if (bus.rd_step && rd_ptr != PTR_LAST)
      rd_ptr_next = rd_ptr + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lcd_off_q       <= 1'b1;
      wr_ptr          <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.frame_done  <= 1'b0;
      bus.partial_cnt <= '0;
      bus.drop_cnt    <= '0;
      bus.repeat_cnt  <= '0;
    end else begin
      lcd_off_q       <= bus.lcd_off;
      bus.wr_en       <= accept;
      bus.frame_done  <= commit;
      bus.partial_cnt <= sat_inc(bus.partial_cnt, discard);
      bus.drop_cnt    <= sat_inc(bus.drop_cnt, drop);
      bus.repeat_cnt  <= sat_inc(bus.repeat_cnt, rep);
      if (accept) begin
        bus.wr_addr <= AW'(bank_base(w_bank)) + AW'(wr_ptr);
        bus.wr_data <= bus.data;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (commit || discard) begin
        wr_ptr <= '0;
      end
    end
  end

  // Read address follows the post-event bank/pointer so it lands with the swap.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      bus.rd_addr <= AW'(PIXELS);
    end else begin
      rd_ptr      <= rd_ptr_next;
      bus.rd_addr <= AW'(bank_base(r_bank_next)) + AW'(rd_ptr_next);
    end
  end

  assign bus.wr_bank     = w_bank;
  assign bus.rd_bank     = r_bank;
  assign bus.spare_valid = spare_valid;

endmodule
`default_nettype wire

// File: tb/tb_lcd_fb_sched.sv
`timescale 1ns/1ps
// Directed self-checking bench for lcd_fb_sched.
module tb_lcd_fb_sched;

  localparam int PIX = 23040;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   wr_pulses = 0;
  int   last_addr = -1;
  int   max_addr  = -1;

  lcd_fb_sched_if #(.AW(17), .CW(8)) bus ();

  lcd_fb_sched dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (bus.wr_en === 1'b1) begin
      wr_pulses = wr_pulses + 1;
      last_addr = int'(bus.wr_addr);
      if (last_addr > max_addr) max_addr = last_addr;
    end
  end

  task automatic clear_mon();
    wr_pulses = 0;
    last_addr = -1;
    max_addr  = -1;
  endtask

  task automatic push(input int n, input int dbase);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      bus.ce_cpu = 1'b1;
      bus.clkena = 1'b1;
      bus.data   = 15'(dbase + i);
    end
    @(negedge clk_sys);
    bus.ce_cpu = 1'b0;
    bus.clkena = 1'b0;
  endtask

  task automatic raise_lcd_off();
    @(negedge clk_sys);
    bus.lcd_off = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    bus.ce_cpu = 0; bus.clkena = 0; bus.data = '0; bus.lcd_off = 1;
    bus.rd_frame_start = 0; bus.rd_step = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    total++;
    if ({bus.wr_bank, bus.rd_bank, bus.spare_valid, bus.frame_done} !== {2'd0, 2'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_banks: got W=%0d R=%0d sv=%0b fd=%0b want W=0 R=1 sv=0 fd=0",
                      bus.wr_bank, bus.rd_bank, bus.spare_valid, bus.frame_done);
    end
    total++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b0, 17'd0, 15'd0}) begin
      bad++; $display("FAIL reset_write: got en=%0b addr=%0d data=%0h want 0/0/0",
                      bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    total++;
    if (bus.rd_addr !== 17'd23040) begin
      bad++; $display("FAIL reset_rd_addr: got %0d want 23040", bus.rd_addr);
    end
    total++;
    if ({bus.drop_cnt, bus.repeat_cnt, bus.partial_cnt} !== 24'd0) begin
      bad++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
                      bus.drop_cnt, bus.repeat_cnt, bus.partial_cnt);
    end
  endtask

  // 23050 pixels into bank 0: only the first 23040 are written, then the frame commits.
  task automatic test_full_overflow();
    @(negedge clk_sys);
    bus.lcd_off = 1'b0;
    clear_mon();
    push(PIX + 10, 0);
    @(negedge clk_sys);
    #1;
    total++;
    if (wr_pulses !== PIX) begin
      bad++; $display("FAIL overflow_pulses: got %0d want %0d", wr_pulses, PIX);
    end
    total++;
    if (max_addr !== 23039 || last_addr !== 23039) begin
      bad++; $display("FAIL overflow_addr: got max=%0d last=%0d want 23039", max_addr, last_addr);
    end
    total++;
    if (bus.wr_data !== 15'd23039) begin
      bad++; $display("FAIL overflow_data: got %0d want 23039", bus.wr_data);
    end
    raise_lcd_off();
    total++;
    if ({bus.frame_done, bus.wr_bank, bus.rd_bank, bus.spare_valid} !== {1'b1, 2'd2, 2'd1, 1'b1}) begin
      bad++; $display("FAIL commit1: got fd=%0b W=%0d R=%0d sv=%0b want fd=1 W=2 R=1 sv=1",
                      bus.frame_done, bus.wr_bank, bus.rd_bank, bus.spare_valid);
    end
    @(negedge clk_sys);
    total++;
    if (bus.frame_done !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      bad++; $display("FAIL commit1_pulse: got fd=%0b drop=%0d want 0/0", bus.frame_done, bus.drop_cnt);
    end
  endtask

  // 100 pixels then frame end is discarded; W=2 is reused from address 46080.
  task automatic test_partial();
    bus.lcd_off = 1'b0;
    push(100, 1000);
    raise_lcd_off();
    total++;
    if ({bus.partial_cnt, bus.wr_bank, bus.frame_done, bus.spare_valid} !== {8'd1, 2'd2, 1'b0, 1'b1}) begin
      bad++; $display("FAIL partial: got cnt=%0d W=%0d fd=%0b sv=%0b want 1/2/0/1",
                      bus.partial_cnt, bus.wr_bank, bus.frame_done, bus.spare_valid);
    end
    @(negedge clk_sys);
    bus.lcd_off = 1'b0;
    push(1, 15'h2abc);
    total++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 17'd46080, 15'h2abc}) begin
      bad++; $display("FAIL partial_restart: got en=%0b addr=%0d data=%0h want 1/46080/2abc",
                      bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    push(PIX - 1, 7);
    raise_lcd_off();
    // Spare already held an unshown frame, so this commit drops it.
    total++;
    if ({bus.frame_done, bus.wr_bank, bus.spare_valid, bus.drop_cnt} !== {1'b1, 2'd0, 1'b1, 8'd1}) begin
      bad++; $display("FAIL commit2_drop: got fd=%0b W=%0d sv=%0b drop=%0d want 1/0/1/1",
                      bus.frame_done, bus.wr_bank, bus.spare_valid, bus.drop_cnt);
    end
  endtask

  task automatic test_read();
    @(negedge clk_sys);
    bus.lcd_off = 1'b0;
    bus.rd_frame_start = 1'b1;
    @(negedge clk_sys);
    bus.rd_frame_start = 1'b0;
    total++;
    if ({bus.rd_bank, bus.spare_valid, bus.repeat_cnt, bus.rd_addr} !== {2'd2, 1'b0, 8'd0, 17'd46080}) begin
      bad++; $display("FAIL rd_swap: got R=%0d sv=%0b rep=%0d addr=%0d want 2/0/0/46080",
                      bus.rd_bank, bus.spare_valid, bus.repeat_cnt, bus.rd_addr);
    end
    for (int i = 0; i < 5; i++) begin
      bus.rd_step = 1'b1;
      @(negedge clk_sys);
    end
    bus.rd_step = 1'b0;
    total++;
    if (bus.rd_addr !== 17'd46085) begin
      bad++; $display("FAIL rd_step5: got %0d want 46085", bus.rd_addr);
    end
    // Second frame start with no new frame repeats R; start beats a coincident step.
    bus.rd_frame_start = 1'b1;
    bus.rd_step = 1'b1;
    @(negedge clk_sys);
    bus.rd_frame_start = 1'b0;
    bus.rd_step = 1'b0;
    total++;
    if ({bus.rd_bank, bus.repeat_cnt, bus.rd_addr, bus.wr_bank} !== {2'd2, 8'd1, 17'd46080, 2'd0}) begin
      bad++; $display("FAIL rd_repeat: got R=%0d rep=%0d addr=%0d W=%0d want 2/1/46080/0",
                      bus.rd_bank, bus.repeat_cnt, bus.rd_addr, bus.wr_bank);
    end
  endtask

  // From W=0,R=2,S=1: commit then reader swap gives W=1,R=0,S=2.
  task automatic test_simultaneous();
    @(negedge clk_sys);
    push(PIX, 3);
    @(negedge clk_sys);
    bus.lcd_off = 1'b1;
    bus.rd_frame_start = 1'b1;
    @(negedge clk_sys);
    bus.rd_frame_start = 1'b0;
    total++;
    if ({bus.wr_bank, bus.rd_bank, bus.spare_valid, bus.frame_done} !== {2'd1, 2'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL simul_banks: got W=%0d R=%0d sv=%0b fd=%0b want 1/0/0/1",
                      bus.wr_bank, bus.rd_bank, bus.spare_valid, bus.frame_done);
    end
    total++;
    if ({bus.drop_cnt, bus.repeat_cnt, bus.rd_addr} !== {8'd1, 8'd1, 17'd0}) begin
      bad++; $display("FAIL simul_counts: got drop=%0d rep=%0d rd_addr=%0d want 1/1/0",
                      bus.drop_cnt, bus.repeat_cnt, bus.rd_addr);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_sys);
    bus.lcd_off = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_sys);
      bus.ce_cpu = 1'b1;
      bus.clkena = 1'b1;
      bus.data   = 15'(i);
    end
    @(posedge clk_sys);
    #2;
    total++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 17'd28039) begin
      bad++; $display("FAIL mid_write: got en=%0b addr=%0d want 1/28039", bus.wr_en, bus.wr_addr);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_addr} !== {1'b0, 17'd0, 15'd0, 17'd23040}) begin
      bad++; $display("FAIL mid_reset_addr: got en=%0b wa=%0d wd=%0h ra=%0d want 0/0/0/23040",
                      bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_addr);
    end
    total++;
    if ({bus.wr_bank, bus.rd_bank, bus.spare_valid, bus.drop_cnt, bus.repeat_cnt, bus.partial_cnt}
        !== {2'd0, 2'd1, 1'b0, 24'd0}) begin
      bad++; $display("FAIL mid_reset_state: got W=%0d R=%0d sv=%0b cnt=%0d/%0d/%0d want 0/1/0/0/0/0",
                      bus.wr_bank, bus.rd_bank, bus.spare_valid,
                      bus.drop_cnt, bus.repeat_cnt, bus.partial_cnt);
    end
    bus.ce_cpu = 1'b0;
    bus.clkena = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_overflow();
    test_partial();
    test_read();
    test_simultaneous();
    test_reset_mid();
    repeat (2) @(negedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
